// File: rtl/simple_vedic_8bit.sv
// Unsigned 8x8 Urdhva-Tiryagbhyam multiplier built from 2x2 and 4x4 cells.
// Combinational product on s, plus a registered copy on s_q.
module vedic_2x2 (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic [3:0] o_p
);
    logic w_x10;
    logic w_x01;
    logic w_hh;
    logic w_c1;

    assign w_x10  = i_a[1] & i_b[0];
    assign w_x01  = i_a[0] & i_b[1];
    assign w_hh   = i_a[1] & i_b[1];
    assign w_c1   = w_x10 & w_x01;
    assign o_p[0] = i_a[0] & i_b[0];
    assign o_p[1] = w_x10 ^ w_x01;
    assign o_p[2] = w_hh ^ w_c1;
    assign o_p[3] = w_hh & w_c1;
endmodule

// Operands are zero-extended to the full result width, so no carry is lost.
module vedic_rca #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    output logic [W-1:0] o_sum
);
    logic w_c;

    always_comb begin
        w_c   = 1'b0;
        o_sum = '0;
        for (int i = 0; i < W; i++) begin
            o_sum[i] = i_x[i] ^ i_y[i] ^ w_c;
            w_c      = (i_x[i] & i_y[i]) | (w_c & (i_x[i] ^ i_y[i]));
        end
    end
endmodule

module vedic_4x4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    logic [3:0] w_ll;
    logic [3:0] w_lh;
    logic [3:0] w_hl;
    logic [3:0] w_hh;
    logic [4:0] w_mid;
    logic [7:0] w_part;

    vedic_2x2 u_ll (.i_a(i_a[1:0]), .i_b(i_b[1:0]), .o_p(w_ll));
    vedic_2x2 u_lh (.i_a(i_a[1:0]), .i_b(i_b[3:2]), .o_p(w_lh));
    vedic_2x2 u_hl (.i_a(i_a[3:2]), .i_b(i_b[1:0]), .o_p(w_hl));
    vedic_2x2 u_hh (.i_a(i_a[3:2]), .i_b(i_b[3:2]), .o_p(w_hh));

    vedic_rca #(.W(5)) u_mid (
        .i_x({1'b0, w_lh}),
        .i_y({1'b0, w_hl}),
        .o_sum(w_mid)
    );
    vedic_rca #(.W(8)) u_lo (
        .i_x({4'b0, w_ll}),
        .i_y({1'b0, w_mid, 2'b0}),
        .o_sum(w_part)
    );
    vedic_rca #(.W(8)) u_hi (
        .i_x(w_part),
        .i_y({w_hh, 4'b0}),
        .o_sum(o_p)
    );
endmodule

module simple_vedic_8bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] s,
    output logic [15:0] s_q
);
    logic [7:0]  w_ll;
    logic [7:0]  w_lh;
    logic [7:0]  w_hl;
    logic [7:0]  w_hh;
    logic [8:0]  w_mid;
    logic [15:0] w_part;
    logic [15:0] w_s;
    logic [15:0] r_s_q;

    vedic_4x4 u_ll (.i_a(a[3:0]), .i_b(b[3:0]), .o_p(w_ll));
    vedic_4x4 u_lh (.i_a(a[3:0]), .i_b(b[7:4]), .o_p(w_lh));
    vedic_4x4 u_hl (.i_a(a[7:4]), .i_b(b[3:0]), .o_p(w_hl));
    vedic_4x4 u_hh (.i_a(a[7:4]), .i_b(b[7:4]), .o_p(w_hh));

    vedic_rca #(.W(9)) u_mid (
        .i_x({1'b0, w_lh}),
        .i_y({1'b0, w_hl}),
        .o_sum(w_mid)
    );
    vedic_rca #(.W(16)) u_lo (
        .i_x({8'b0, w_ll}),
        .i_y({3'b0, w_mid, 4'b0}),
        .o_sum(w_part)
    );
    vedic_rca #(.W(16)) u_hi (
        .i_x(w_part),
        .i_y({w_hh, 8'b0}),
        .o_sum(w_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_q <= 16'h0000;
        end else begin
            r_s_q <= w_s;
        end
    end

    assign s   = w_s;
    assign s_q = r_s_q;
endmodule

// File: tb/tb_simple_vedic_8bit.sv
// Self-checking bench for simple_vedic_8bit against an arithmetic model.
// Directed, random, exhaustive and reset scenarios.
module tb_simple_vedic_8bit;
    logic        clk;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] s;
    logic [15:0] s_q;

    int checks;
    int errors;

    simple_vedic_8bit dut (
        .clk(clk),
        .rst_n(rst_n),
        .a(a),
        .b(b),
        .s(s),
        .s_q(s_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = int'(x) * int'(y);
        return p[15:0];
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if (s_q !== 16'h0000) begin
            errors++;
            $display("FAIL reset_sq got %h want 0000", s_q);
        end
        checks++;
        if (s !== model(a, b)) begin
            errors++;
            $display("FAIL reset_s got %h want %h", s, model(a, b));
        end
    endtask

    task automatic test_directed();
        logic [7:0]  ta [7];
        logic [7:0]  tb [7];
        logic [15:0] te [7];
        ta = '{8'h00, 8'h00, 8'hFF, 8'h01, 8'h80, 8'hAA, 8'h0F};
        tb = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h55, 8'hF0};
        te = '{16'h0000, 16'h0000, 16'hFE01, 16'h00FF,
               16'h0100, 16'h3872, 16'h0E10};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            a = ta[i];
            b = tb[i];
            @(negedge clk);
            checks++;
            if (s !== te[i]) begin
                errors++;
                $display("FAIL directed_%0d a=%h b=%h got %h want %h",
                         i, ta[i], tb[i], s, te[i]);
            end
        end
    endtask

    task automatic test_register();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_q !== 16'h0000) begin
            errors++;
            $display("FAIL reg_async_clear got %h want 0000", s_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = 8'h12;
        b = 8'h34;
        @(posedge clk);
        #1;
        checks++;
        if (s_q !== 16'h03A8) begin
            errors++;
            $display("FAIL reg_first got %h want 03A8", s_q);
        end
        a = 8'hFF;
        b = 8'hFF;
        @(posedge clk);
        #1;
        checks++;
        if (s_q !== 16'hFE01) begin
            errors++;
            $display("FAIL reg_second got %h want FE01", s_q);
        end
    endtask

    task automatic test_random();
        logic [15:0] prev;
        prev = model(a, b);
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (s_q !== prev) begin
                errors++;
                $display("FAIL random_sq cycle %0d got %h want %h", i, s_q, prev);
                break;
            end
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            @(negedge clk);
            checks++;
            if (s !== model(a, b)) begin
                errors++;
                $display("FAIL random_s a=%h b=%h got %h want %h",
                         a, b, s, model(a, b));
                break;
            end
            prev = model(a, b);
        end
    endtask

    task automatic test_exhaustive();
        logic [15:0] idx;
        for (int i = 0; i < 65536; i++) begin
            idx = 16'(i);
            a = idx[15:8];
            b = idx[7:0];
            #1;
            checks++;
            if (s !== model(a, b)) begin
                errors++;
                $display("FAIL exhaustive a=%h b=%h got %h want %h",
                         a, b, s, model(a, b));
                break;
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            a = 8'($urandom_range(1, 255));
            b = 8'($urandom_range(1, 255));
            @(negedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            checks++;
            if (s_q !== 16'h0000) begin
                errors++;
                $display("FAIL mid_clear_%0d got %h want 0000", k, s_q);
            end
            a = 8'($urandom_range(1, 255));
            b = 8'($urandom_range(1, 255));
            #1;
            checks++;
            if (s !== model(a, b)) begin
                errors++;
                $display("FAIL mid_s_%0d got %h want %h", k, s, model(a, b));
            end
            if (k == 3) begin
                @(posedge clk);
                #1;
                checks++;
                if (s_q !== 16'h0000) begin
                    errors++;
                    $display("FAIL mid_hold_in_reset got %h want 0000", s_q);
                end
                @(negedge clk);
            end
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (s_q !== model(a, b)) begin
                errors++;
                $display("FAIL mid_reload_%0d got %h want %h", k, s_q, model(a, b));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a      = 8'h5A;
        b      = 8'hC3;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_directed();
        test_register();
        test_random();
        test_reset_midstream();
        test_exhaustive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
